// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit. The carry chain is split into STAGES slices, and an
// elastic valid/ready pipeline moves each operation through one slice per stage.
module addsub_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int unsigned S    = WIDTH / STAGES;
    localparam int unsigned SW   = S + 1;
    localparam int unsigned LAST = STAGES - 1;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  r_q [STAGES];
    logic [WIDTH-1:0]  r_d [STAGES];
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;

    // Flow control plus one carry slice per stage; b is stored already inverted for subtract.
    always_comb begin
        logic              free;
        logic [STAGES-1:0] adv;
        logic              load;
        logic [WIDTH-1:0]  a_src;
        logic [WIDTH-1:0]  b_src;
        logic [WIDTH-1:0]  r_src;
        logic [WIDTH-1:0]  r_new;
        logic              c_src;
        logic [S:0]        ssum;

        valid_d = valid_q;
        c_d     = c_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        adv     = '0;
        load    = 1'b0;
        a_src   = '0;
        b_src   = '0;
        r_src   = '0;
        r_new   = '0;
        c_src   = 1'b0;
        ssum    = '0;

        // Walk back from the output: a stage advances when it is full and the stage after it is free.
        free = out_ready;
        for (int k = int'(LAST); k >= 0; k--) begin
            adv[k] = valid_q[k] && free;
            free   = !valid_q[k] || adv[k];
        end
        in_ready = free;

        for (int k = 0; k < int'(STAGES); k++) begin
            if (k == 0) begin
                a_src = a;
                b_src = sub ? ~b : b;
                c_src = sub ? ~cin : cin;
                r_src = '0;
                load  = in_valid && free;
            end else begin
                a_src = a_q[k-1];
                b_src = b_q[k-1];
                c_src = c_q[k-1];
                r_src = r_q[k-1];
                load  = adv[k-1];
            end

            ssum  = SW'(a_src[k*S +: S]) + SW'(b_src[k*S +: S]) + SW'(c_src);
            r_new = r_src;
            r_new[k*S +: S] = ssum[S-1:0];

            if (load) begin
                valid_d[k] = 1'b1;
                a_d[k]     = a_src;
                b_d[k]     = b_src;
                r_d[k]     = r_new;
                c_d[k]     = ssum[S];
                if (k == int'(LAST)) begin
                    zero_d = (r_new == '0);
                    neg_d  = r_new[WIDTH-1];
                    ovf_d  = (a_src[WIDTH-1] == b_src[WIDTH-1]) && (r_new[WIDTH-1] != a_src[WIDTH-1]);
                end
            end else if (adv[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            c_q     <= '0;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            r_q     <= '{default: '0};
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            c_q     <= c_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = valid_q[LAST];
    assign result    = r_q[LAST];
    assign cout      = c_q[LAST];
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;

endmodule
